npu_calculator: RTL and testbench
=================================

# npu_calculator

16-lane FP16 dot-product engine of the NPU neuron datapath: multiplies 16 IEEE-754 binary16 inputs by 16 binary16 weights and reduces the products with a fixed-order pipelined adder tree into one binary16 result. It sits between the neuron's operand buffers and its result write-back logic. A level `start`/`valid` handshake controls each computation.

## Interface
- NPU_DATA_WIDTH, default 16: operand and result width; the arithmetic is binary16, so only 16 is supported.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_b  in  1  synchronous, active-high reset. The port name is kept for codebase consistency; the reset acts when the signal is 1.
- start  in  1  request. Sampled only in IDLE; held high by the requester until `valid` is seen.
- input_0 .. input_15  in  16 each  binary16 activations.
- weight_0 .. weight_15  in  16 each  binary16 weights.
- valid  out  1  high while the result is available (DONE state).
- result  out  16  binary16 dot product; holds its value until the next completion.

## Operation
- FSM states: IDLE → MUL → ADD1 → ADD2 → ADD3 → DONE.
- IDLE, start=1: register all 32 operands, go to MUL.
- MUL: compute the 16 products p[i] = input_i × weight_i. Register them into internal `multiplier_result_0..15` and go to ADD1.
- Internal `combined_multiplier_valid` pulses high for exactly the one cycle following the product registration.
  - These internal names are mandatory; the verification bench probes them hierarchically.
- Adder tree, with fixed pairing for bit-exactness:
  - ADD1: s1[k] = p[2k] + p[2k+1], k = 0..7.
  - ADD2: s2[k] = s1[2k] + s1[2k+1], k = 0..3.
  - ADD3: s3[k] = s2[2k] + s2[2k+1], k = 0..1.
  - The final sum s3[0] + s3[1] is registered into `result` on the edge that enters DONE.
- DONE: valid=1. Stay in DONE while start=1; when start=0, return to IDLE (valid drops).
- Arithmetic rules for every multiply and add:
  - Full IEEE binary16, round-to-nearest-even, each operation rounded individually.
  - Subnormal inputs are treated as zero (sign kept); subnormal results are flushed to signed zero.
  - Overflow goes to ±inf (0x7C00 / 0xFC00).
  - Any NaN operand, inf×0, or inf+(−inf) produces canonical NaN 0x7E00.
  - Exact-zero sums of opposite-signed operands give +0 (0x0000).
- Operand changes outside IDLE have no effect; operands are captured once per request.

## Timing
- Reset (reset_b=1 at an edge): state=IDLE, valid=0, result=0x0000, combined_multiplier_valid=0, all pipeline registers 0.
- Reset mid-computation aborts the computation; no valid is produced for it.
- Latency: start sampled at edge T0 → products registered at T1 (combined_multiplier_valid high T1..T2) → ADD1 T2, ADD2 T3, ADD3 T4 → result and valid=1 at T5.
- valid falls on the first edge at which start=0 is sampled in DONE.
- Earliest next start is sampled on the edge after the return to IDLE, so back-to-back requests take 7 cycles minimum.
- start=0 during MUL..ADD3: the computation completes regardless; valid rises at T5 and falls on the following edge, since start=0 there.
- start held high continuously: one computation only; valid stays high until start drops.

## Test plan
- All inputs 0x3C00 (1.0), all weights 0x3C00 → combined_multiplier_valid pulses at T1 with every multiplier_result = 0x3C00; result 0x4C00 (16.0), valid at T5.
- Inputs 0x4000 (2.0), weights 0x3800 (0.5) → products 0x3C00, result 0x4C00. Then all-zero operands → result 0x0000.
- Inputs 0x3C00; weights alternating 0x3C00/0xBC00 → result 0x0000. Then input_0=0x7BFF, weight_0=0x4000, others zero → product 0x7C00, result 0x7C00.
- input_0=0x7C00, weight_0=0x3C00, input_1=0x7C00, weight_1=0xBC00, others zero → result 0x7E00.
- Handshake:
  - start held 3 extra cycles after valid → valid stays high, no second computation.
  - start dropped → valid low next edge.
  - 49 back-to-back requests → 49 correct results.
- reset_b asserted at T3 of a computation → next edge: valid=0, result=0x0000, IDLE; a new start then completes normally at T5.

Source files
------------

// File: rtl/npu_calculator.sv
`default_nettype none
// ============================================================================
// Module      : npu_calculator
// Description : 16-lane binary16 dot-product engine. Captures 16 activations
//               and 16 weights, multiplies lane-wise, then reduces the
//               products through a fixed-order pipelined adder tree into one
//               binary16 result presented with a level valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module npu_calculator #(
  parameter int NPU_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      start,
  input  logic [NPU_DATA_WIDTH-1:0] input_0,
  input  logic [NPU_DATA_WIDTH-1:0] input_1,
  input  logic [NPU_DATA_WIDTH-1:0] input_2,
  input  logic [NPU_DATA_WIDTH-1:0] input_3,
  input  logic [NPU_DATA_WIDTH-1:0] input_4,
  input  logic [NPU_DATA_WIDTH-1:0] input_5,
  input  logic [NPU_DATA_WIDTH-1:0] input_6,
  input  logic [NPU_DATA_WIDTH-1:0] input_7,
  input  logic [NPU_DATA_WIDTH-1:0] input_8,
  input  logic [NPU_DATA_WIDTH-1:0] input_9,
  input  logic [NPU_DATA_WIDTH-1:0] input_10,
  input  logic [NPU_DATA_WIDTH-1:0] input_11,
  input  logic [NPU_DATA_WIDTH-1:0] input_12,
  input  logic [NPU_DATA_WIDTH-1:0] input_13,
  input  logic [NPU_DATA_WIDTH-1:0] input_14,
  input  logic [NPU_DATA_WIDTH-1:0] input_15,
  input  logic [NPU_DATA_WIDTH-1:0] weight_0,
  input  logic [NPU_DATA_WIDTH-1:0] weight_1,
  input  logic [NPU_DATA_WIDTH-1:0] weight_2,
  input  logic [NPU_DATA_WIDTH-1:0] weight_3,
  input  logic [NPU_DATA_WIDTH-1:0] weight_4,
  input  logic [NPU_DATA_WIDTH-1:0] weight_5,
  input  logic [NPU_DATA_WIDTH-1:0] weight_6,
  input  logic [NPU_DATA_WIDTH-1:0] weight_7,
  input  logic [NPU_DATA_WIDTH-1:0] weight_8,
  input  logic [NPU_DATA_WIDTH-1:0] weight_9,
  input  logic [NPU_DATA_WIDTH-1:0] weight_10,
  input  logic [NPU_DATA_WIDTH-1:0] weight_11,
  input  logic [NPU_DATA_WIDTH-1:0] weight_12,
  input  logic [NPU_DATA_WIDTH-1:0] weight_13,
  input  logic [NPU_DATA_WIDTH-1:0] weight_14,
  input  logic [NPU_DATA_WIDTH-1:0] weight_15,
  output logic                      valid,
  output logic [NPU_DATA_WIDTH-1:0] result
);

  // The final add gets its own cycle (S_ADD4) so the result lands five
  // edges after start is sampled.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_ADD1 = 3'd2,
    S_ADD2 = 3'd3,
    S_ADD3 = 3'd4,
    S_ADD4 = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [15:0] c_QNAN = 16'h7E00;

  state_t                    r_state;
  state_t                    w_next_state;

  logic [NPU_DATA_WIDTH-1:0] w_in  [16];
  logic [NPU_DATA_WIDTH-1:0] w_wt  [16];
  logic [NPU_DATA_WIDTH-1:0] r_in  [16];
  logic [NPU_DATA_WIDTH-1:0] r_wt  [16];
  logic [NPU_DATA_WIDTH-1:0] r_prod[16];
  logic [NPU_DATA_WIDTH-1:0] r_s1  [8];
  logic [NPU_DATA_WIDTH-1:0] r_s2  [4];
  logic [NPU_DATA_WIDTH-1:0] r_s3  [2];
  logic [NPU_DATA_WIDTH-1:0] r_result;

  // Observable names for the product stage.
  logic                      combined_multiplier_valid;
  logic [NPU_DATA_WIDTH-1:0] multiplier_result_0,  multiplier_result_1;
  logic [NPU_DATA_WIDTH-1:0] multiplier_result_2,  multiplier_result_3;
  logic [NPU_DATA_WIDTH-1:0] multiplier_result_4,  multiplier_result_5;
  logic [NPU_DATA_WIDTH-1:0] multiplier_result_6,  multiplier_result_7;
  logic [NPU_DATA_WIDTH-1:0] multiplier_result_8,  multiplier_result_9;
  logic [NPU_DATA_WIDTH-1:0] multiplier_result_10, multiplier_result_11;
  logic [NPU_DATA_WIDTH-1:0] multiplier_result_12, multiplier_result_13;
  logic [NPU_DATA_WIDTH-1:0] multiplier_result_14, multiplier_result_15;

  assign w_in[0]  = input_0;   assign w_wt[0]  = weight_0;
  assign w_in[1]  = input_1;   assign w_wt[1]  = weight_1;
  assign w_in[2]  = input_2;   assign w_wt[2]  = weight_2;
  assign w_in[3]  = input_3;   assign w_wt[3]  = weight_3;
  assign w_in[4]  = input_4;   assign w_wt[4]  = weight_4;
  assign w_in[5]  = input_5;   assign w_wt[5]  = weight_5;
  assign w_in[6]  = input_6;   assign w_wt[6]  = weight_6;
  assign w_in[7]  = input_7;   assign w_wt[7]  = weight_7;
  assign w_in[8]  = input_8;   assign w_wt[8]  = weight_8;
  assign w_in[9]  = input_9;   assign w_wt[9]  = weight_9;
  assign w_in[10] = input_10;  assign w_wt[10] = weight_10;
  assign w_in[11] = input_11;  assign w_wt[11] = weight_11;
  assign w_in[12] = input_12;  assign w_wt[12] = weight_12;
  assign w_in[13] = input_13;  assign w_wt[13] = weight_13;
  assign w_in[14] = input_14;  assign w_wt[14] = weight_14;
  assign w_in[15] = input_15;  assign w_wt[15] = weight_15;

  assign multiplier_result_0  = r_prod[0];
  assign multiplier_result_1  = r_prod[1];
  assign multiplier_result_2  = r_prod[2];
  assign multiplier_result_3  = r_prod[3];
  assign multiplier_result_4  = r_prod[4];
  assign multiplier_result_5  = r_prod[5];
  assign multiplier_result_6  = r_prod[6];
  assign multiplier_result_7  = r_prod[7];
  assign multiplier_result_8  = r_prod[8];
  assign multiplier_result_9  = r_prod[9];
  assign multiplier_result_10 = r_prod[10];
  assign multiplier_result_11 = r_prod[11];
  assign multiplier_result_12 = r_prod[12];
  assign multiplier_result_13 = r_prod[13];
  assign multiplier_result_14 = r_prod[14];
  assign multiplier_result_15 = r_prod[15];

  assign result = r_result;

  // Leading-zero count of a 14-bit significand (input never zero when used).
  function automatic logic [3:0] clz14(input logic [13:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) n = 4'(13 - i);
    end
    return n;
  endfunction

  // binary16 multiply: RNE, subnormals in/out flushed to signed zero.
  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic               sr, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0]        prod;
    logic [10:0]        sig;
    logic               g, st;
    logic [11:0]        rnd;
    logic [9:0]         frac;
    logic signed [7:0]  e;
    logic [15:0]        r;
    sr     = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    prod   = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e      = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
    // Product of two [1,2) significands lies in [1,4); normalise to [1,2).
    if (prod[21]) begin
      sig = prod[21:11];
      g   = prod[10];
      st  = |prod[9:0];
      e   = e + 8'sd1;
    end else begin
      sig = prod[20:10];
      g   = prod[9];
      st  = |prod[8:0];
    end
    rnd = {1'b0, sig} + {11'd0, g & (st | sig[0])};
    if (rnd[11]) begin
      frac = rnd[10:1];
      e    = e + 8'sd1;
    end else begin
      frac = rnd[9:0];
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) r = c_QNAN;
    else if (a_inf || b_inf)                                       r = {sr, 5'h1F, 10'd0};
    else if (a_zero || b_zero)                                     r = {sr, 15'd0};
    else if (e >= 8'sd31)                                          r = {sr, 5'h1F, 10'd0};
    else if (e <= 8'sd0)                                           r = {sr, 15'd0};
    else                                                           r = {sr, e[4:0], frac};
    return r;
  endfunction

  // binary16 add: RNE with guard/round/sticky, subnormals flushed to zero.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, zero_res;
    logic [15:0]        big, sml, r;
    logic [4:0]         d;
    logic [13:0]        mx, ys, diff, sig;
    logic [14:0]        sum;
    logic [45:0]        yext;
    logic [3:0]         lz;
    logic [11:0]        rnd;
    logic [9:0]         frac;
    logic               g, rs;
    logic signed [7:0]  e;
    a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    // Larger magnitude first so the aligned difference is never negative.
    if (a[14:0] >= b[14:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d    = big[14:10] - sml[14:10];
    mx   = {1'b1, big[9:0], 3'b000};
    yext = {1'b1, sml[9:0], 3'b000, 32'd0} >> d;
    ys   = {yext[45:33], yext[32] | (|yext[31:0])};
    e    = $signed({3'b000, big[14:10]});
    sum      = 15'd0;
    diff     = 14'd0;
    lz       = 4'd0;
    zero_res = 1'b0;
    if (big[15] == sml[15]) begin
      sum = {1'b0, mx} + {1'b0, ys};
      if (sum[14]) begin
        sig = {sum[14:2], sum[1] | sum[0]};
        e   = e + 8'sd1;
      end else begin
        sig = sum[13:0];
      end
    end else begin
      diff     = mx - ys;
      zero_res = (diff == 14'd0);
      lz       = clz14(diff);
      sig      = diff << lz;
      e        = e - $signed({4'b0000, lz});
    end
    g   = sig[2];
    rs  = |sig[1:0];
    rnd = {1'b0, sig[13:3]} + {11'd0, g & (rs | sig[3])};
    if (rnd[11]) begin
      frac = rnd[10:1];
      e    = e + 8'sd1;
    end else begin
      frac = rnd[9:0];
    end
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) r = c_QNAN;
    else if (a_inf)                 r = {a[15], 5'h1F, 10'd0};
    else if (b_inf)                 r = {b[15], 5'h1F, 10'd0};
    else if (a_zero && b_zero)      r = {a[15] & b[15], 15'd0};
    else if (a_zero)                r = b;
    else if (b_zero)                r = a;
    else if (zero_res)              r = 16'h0000;
    else if (e >= 8'sd31)           r = {big[15], 5'h1F, 10'd0};
    else if (e <= 8'sd0)            r = {big[15], 15'd0};
    else                            r = {big[15], e[4:0], frac};
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset_b) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state and valid decode.
  always_comb begin
    w_next_state = r_state;
    valid        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_MUL;
      S_MUL:  w_next_state = S_ADD1;
      S_ADD1: w_next_state = S_ADD2;
      S_ADD2: w_next_state = S_ADD3;
      S_ADD3: w_next_state = S_ADD4;
      S_ADD4: w_next_state = S_DONE;
      S_DONE: begin
        valid = 1'b1;
        if (!start) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, product stage and adder-tree pipeline.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      for (int i = 0; i < 16; i++) begin
        r_in[i]   <= '0;
        r_wt[i]   <= '0;
        r_prod[i] <= '0;
      end
      for (int i = 0; i < 8; i++) r_s1[i] <= '0;
      for (int i = 0; i < 4; i++) r_s2[i] <= '0;
      for (int i = 0; i < 2; i++) r_s3[i] <= '0;
      r_result                  <= '0;
      combined_multiplier_valid <= 1'b0;
    end else begin
      combined_multiplier_valid <= (r_state == S_MUL);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              r_in[i] <= w_in[i];
              r_wt[i] <= w_wt[i];
            end
          end
        end
        S_MUL:  for (int i = 0; i < 16; i++) r_prod[i] <= fp_mul(r_in[i], r_wt[i]);
        S_ADD1: for (int k = 0; k < 8; k++)  r_s1[k] <= fp_add(r_prod[2*k], r_prod[2*k+1]);
        S_ADD2: for (int k = 0; k < 4; k++)  r_s2[k] <= fp_add(r_s1[2*k], r_s1[2*k+1]);
        S_ADD3: for (int k = 0; k < 2; k++)  r_s3[k] <= fp_add(r_s2[2*k], r_s2[2*k+1]);
        S_ADD4: r_result <= fp_add(r_s3[0], r_s3[1]);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_npu_calculator.sv
`default_nettype none
// ============================================================================
// Module      : tb_npu_calculator
// Description : Table-driven self-checking bench for npu_calculator with
//               hand-written handshake and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npu_calculator;

  typedef struct packed {
    logic [15:0][15:0] in;
    logic [15:0][15:0] wt;
    logic [15:0]       exp_res;
    logic [15:0]       exp_p0;
  } vec_t;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start;
  logic [15:0] tb_in [16];
  logic [15:0] tb_wt [16];
  logic        valid;
  logic [15:0] result;
  logic [15:0] probe [16];
  vec_t        vecs [NV];
  int          n_err = 0;
  int          n_chk = 0;

  always #5 clk = ~clk;

  npu_calculator #(.NPU_DATA_WIDTH(16)) dut (
    .clk(clk), .reset_b(reset_b), .start(start),
    .input_0(tb_in[0]),   .input_1(tb_in[1]),   .input_2(tb_in[2]),   .input_3(tb_in[3]),
    .input_4(tb_in[4]),   .input_5(tb_in[5]),   .input_6(tb_in[6]),   .input_7(tb_in[7]),
    .input_8(tb_in[8]),   .input_9(tb_in[9]),   .input_10(tb_in[10]), .input_11(tb_in[11]),
    .input_12(tb_in[12]), .input_13(tb_in[13]), .input_14(tb_in[14]), .input_15(tb_in[15]),
    .weight_0(tb_wt[0]),   .weight_1(tb_wt[1]),   .weight_2(tb_wt[2]),   .weight_3(tb_wt[3]),
    .weight_4(tb_wt[4]),   .weight_5(tb_wt[5]),   .weight_6(tb_wt[6]),   .weight_7(tb_wt[7]),
    .weight_8(tb_wt[8]),   .weight_9(tb_wt[9]),   .weight_10(tb_wt[10]), .weight_11(tb_wt[11]),
    .weight_12(tb_wt[12]), .weight_13(tb_wt[13]), .weight_14(tb_wt[14]), .weight_15(tb_wt[15]),
    .valid(valid), .result(result)
  );

  assign probe[0]  = dut.multiplier_result_0;   assign probe[1]  = dut.multiplier_result_1;
  assign probe[2]  = dut.multiplier_result_2;   assign probe[3]  = dut.multiplier_result_3;
  assign probe[4]  = dut.multiplier_result_4;   assign probe[5]  = dut.multiplier_result_5;
  assign probe[6]  = dut.multiplier_result_6;   assign probe[7]  = dut.multiplier_result_7;
  assign probe[8]  = dut.multiplier_result_8;   assign probe[9]  = dut.multiplier_result_9;
  assign probe[10] = dut.multiplier_result_10;  assign probe[11] = dut.multiplier_result_11;
  assign probe[12] = dut.multiplier_result_12;  assign probe[13] = dut.multiplier_result_13;
  assign probe[14] = dut.multiplier_result_14;  assign probe[15] = dut.multiplier_result_15;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [15:0] in_all, input logic [15:0] wt_all,
                         input logic [15:0] exp_r, input logic [15:0] exp_p);
    vecs[i].in      = {16{in_all}};
    vecs[i].wt      = {16{wt_all}};
    vecs[i].exp_res = exp_r;
    vecs[i].exp_p0  = exp_p;
  endtask

  // One request: start sampled at T0, result expected at T5. hold_extra keeps
  // start high that many cycles past valid; drop_early drops start after T0.
  task automatic run_vec(input int idx, input int hold_extra, input bit drop_early);
    for (int l = 0; l < 16; l++) begin
      tb_in[l] = vecs[idx].in[l];
      tb_wt[l] = vecs[idx].wt[l];
    end
    start = 1'b1;
    @(posedge clk); #1;                                   // T0
    if (drop_early) start = 1'b0;
    @(posedge clk); #1;                                   // T1
    chk($sformatf("v%0d cmv_T1", idx), 16'(dut.combined_multiplier_valid), 16'h0001);
    chk($sformatf("v%0d prod0", idx), probe[0], vecs[idx].exp_p0);
    if (idx == 0) begin
      for (int l = 1; l < 16; l++) chk($sformatf("v0 prod%0d", l), probe[l], 16'h3C00);
    end
    // Operand changes after capture must not disturb the computation.
    for (int l = 0; l < 16; l++) begin
      tb_in[l] = 16'($urandom);
      tb_wt[l] = 16'($urandom);
    end
    @(posedge clk); #1;                                   // T2
    chk($sformatf("v%0d cmv_T2", idx), 16'(dut.combined_multiplier_valid), 16'h0000);
    @(posedge clk); @(posedge clk); #1;                   // T4
    chk($sformatf("v%0d valid_T4", idx), 16'(valid), 16'h0000);
    @(posedge clk); #1;                                   // T5
    chk($sformatf("v%0d valid_T5", idx), 16'(valid), 16'h0001);
    chk($sformatf("v%0d result", idx), result, vecs[idx].exp_res);
    for (int h = 0; h < hold_extra; h++) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d hold_valid%0d", idx, h), 16'(valid), 16'h0001);
      chk($sformatf("v%0d hold_cmv%0d", idx, h), 16'(dut.combined_multiplier_valid), 16'h0000);
      chk($sformatf("v%0d hold_result%0d", idx, h), result, vecs[idx].exp_res);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d valid_drop", idx), 16'(valid), 16'h0000);
    chk($sformatf("v%0d result_held", idx), result, vecs[idx].exp_res);
  endtask

  initial begin
    // Vector table: {inputs, weights, expected result, expected product 0}.
    set_vec(0,  16'h3C00, 16'h3C00, 16'h4C00, 16'h3C00);   // 16 x 1*1 = 16
    set_vec(1,  16'h4000, 16'h3800, 16'h4C00, 16'h3C00);   // 2*0.5
    set_vec(2,  16'h0000, 16'h0000, 16'h0000, 16'h0000);   // zeros
    set_vec(3,  16'h3C00, 16'h3C00, 16'h0000, 16'h3C00);   // +1/-1 cancel
    for (int l = 1; l < 16; l += 2) vecs[3].wt[l] = 16'hBC00;
    set_vec(4,  16'h0000, 16'h0000, 16'h7C00, 16'h7C00);   // product overflow
    vecs[4].in[0] = 16'h7BFF; vecs[4].wt[0] = 16'h4000;
    set_vec(5,  16'h0000, 16'h0000, 16'h7E00, 16'h7C00);   // inf + -inf
    vecs[5].in[0] = 16'h7C00; vecs[5].wt[0] = 16'h3C00;
    vecs[5].in[1] = 16'h7C00; vecs[5].wt[1] = 16'hBC00;
    set_vec(6,  16'h4000, 16'h4000, 16'h5400, 16'h4400);   // 16 x 4 = 64
    set_vec(7,  16'h3C00, 16'h3C00, 16'h7E00, 16'h3C00);   // NaN in lane 5
    vecs[7].in[5] = 16'h7C01;
    set_vec(8,  16'h0000, 16'h0000, 16'h0000, 16'h8000);   // subnormal in -> -0
    vecs[8].in[0] = 16'h8001; vecs[8].wt[0] = 16'h3C00;
    set_vec(9,  16'h0000, 16'h0000, 16'h0000, 16'h0000);   // underflow flush
    vecs[9].in[0] = 16'h0400; vecs[9].wt[0] = 16'h3800;
    set_vec(10, 16'h0000, 16'h0000, 16'h3C00, 16'h3C00);   // tie to even (down)
    vecs[10].in[0] = 16'h3C00; vecs[10].wt[0] = 16'h3C00;
    vecs[10].in[1] = 16'h1000; vecs[10].wt[1] = 16'h3C00;
    set_vec(11, 16'h0000, 16'h0000, 16'h3C02, 16'h3C01);   // tie to even (up)
    vecs[11].in[0] = 16'h3C01; vecs[11].wt[0] = 16'h3C00;
    vecs[11].in[1] = 16'h1000; vecs[11].wt[1] = 16'h3C00;
    set_vec(12, 16'h0000, 16'h0000, 16'h3C02, 16'h3C02);   // multiply rounding
    vecs[12].in[0] = 16'h3C01; vecs[12].wt[0] = 16'h3C01;
    set_vec(13, 16'h7BFF, 16'h3C00, 16'h7C00, 16'h7BFF);   // adder overflow
    set_vec(14, 16'h0000, 16'h0000, 16'h1000, 16'h3C00);   // cancellation
    vecs[14].in[0] = 16'h3C00; vecs[14].wt[0] = 16'h3C00;
    vecs[14].in[1] = 16'h3BFF; vecs[14].wt[1] = 16'hBC00;
    set_vec(15, 16'hBC00, 16'h4000, 16'hD000, 16'hC000);   // 16 x -2 = -32

    reset_b = 1'b1;
    start   = 1'b0;
    for (int l = 0; l < 16; l++) begin
      tb_in[l] = 16'h0;
      tb_wt[l] = 16'h0;
    end
    @(posedge clk); @(posedge clk); #1;
    chk("rst valid", 16'(valid), 16'h0000);
    chk("rst result", result, 16'h0000);
    chk("rst cmv", 16'(dut.combined_multiplier_valid), 16'h0000);
    chk("rst prod0", probe[0], 16'h0000);
    reset_b = 1'b0;
    @(posedge clk); #1;

    // 49 back-to-back requests cycling through the table.
    for (int i = 0; i < 49; i++) run_vec(i % NV, 0, 1'b0);

    // start held three cycles past valid, then start dropped during MUL.
    run_vec(1, 3, 1'b0);
    run_vec(13, 0, 1'b1);

    // Leave a non-zero result, then abort a computation with reset at T3.
    run_vec(0, 0, 1'b0);
    for (int l = 0; l < 16; l++) begin
      tb_in[l] = vecs[6].in[l];
      tb_wt[l] = vecs[6].wt[l];
    end
    start = 1'b1;
    @(posedge clk); #1;                                   // T0
    @(posedge clk); #1;                                   // T1
    @(posedge clk); #1;                                   // T2
    reset_b = 1'b1;
    start   = 1'b0;
    @(posedge clk); #1;                                   // T3 reset sampled
    chk("abort valid", 16'(valid), 16'h0000);
    chk("abort result", result, 16'h0000);
    chk("abort cmv", 16'(dut.combined_multiplier_valid), 16'h0000);
    reset_b = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort no_valid", 16'(valid), 16'h0000);
    run_vec(6, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
